// File: rtl/square_motion_ctrl.sv
// square_motion_ctrl: per-frame bouncing-square origin scheduler with valid/ready handoff
// Define SQUARE_PAUSE_EN to add a pause input that freezes motion while keeping the offer cadence.
module square_motion_ctrl #(
    parameter int   SCREEN_X = 1920,
    parameter int   SCREEN_Y = 1080,
    parameter int   SQUARE_X = 500,
    parameter int   SQUARE_Y = 500,
    parameter int   STEP_X   = 4,
    parameter int   STEP_Y   = 4,
    parameter logic VS_POL   = 1'b1
) (
    input  logic        vpg_pclk,
    input  logic        rst_n,
    input  logic        vpg_vs,
    input  logic        frame_en,
    input  logic        pos_ready,
`ifdef SQUARE_PAUSE_EN
    input  logic        pause,
`endif
    output logic        pos_valid,
    output logic [11:0] pos_x,
    output logic [11:0] pos_y,
    output logic        dir_x,
    output logic        dir_y,
    output logic        bounce,
    output logic        overrun,
    output logic [15:0] frame_cnt
);
    localparam logic [11:0] MAX_X  = 12'(SCREEN_X - SQUARE_X);
    localparam logic [11:0] MAX_Y  = 12'(SCREEN_Y - SQUARE_Y);
    localparam logic [12:0] STEP_X13 = 13'(STEP_X);
    localparam logic [12:0] STEP_Y13 = 13'(STEP_Y);
    typedef enum logic [1:0] {IDLE, WAIT_VS, CALC, OFFER} state_t;
    state_t state, state_nxt;
    logic vs_d, vs_edge, hold, flip_x, flip_y;
    logic [11:0] nxt_x, nxt_y;
`ifdef SQUARE_PAUSE_EN
    assign hold = pause;
`else
    assign hold = 1'b0;
`endif
    // returns {flip, new_pos}; 13-bit sum so pos+step never wraps before the clamp
    function automatic logic [12:0] step_axis(input logic [11:0] pos, input logic dir,
                                              input logic [12:0] step, input logic [11:0] max);
        logic [12:0] up;
        logic [11:0] dn;
        up = {1'b0, pos} + step;
        dn = pos - step[11:0];
        if (!dir)
            return (up >= {1'b0, max}) ? {1'b1, max} : {1'b0, up[11:0]};
        return ({1'b0, pos} <= step) ? {1'b1, 12'd0} : {1'b0, dn};
    endfunction
    assign vs_edge = (vpg_vs == VS_POL) && (vs_d != VS_POL);
    assign {flip_x, nxt_x} = step_axis(pos_x, dir_x, STEP_X13, MAX_X);
    assign {flip_y, nxt_y} = step_axis(pos_y, dir_y, STEP_Y13, MAX_Y);
    always_ff @(posedge vpg_pclk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = frame_en ? WAIT_VS : IDLE;
            WAIT_VS: state_nxt = !frame_en ? IDLE : (vs_edge ? CALC : WAIT_VS);
            CALC:    state_nxt = OFFER;
            OFFER:   state_nxt = !pos_ready ? OFFER : (frame_en ? WAIT_VS : IDLE);
            default: state_nxt = IDLE;
        endcase
    end
    always_comb begin
        pos_valid = (state == OFFER);
        bounce    = (state == CALC) && !hold && (flip_x || flip_y);
        overrun   = vs_edge && ((state == CALC) || (state == OFFER));
    end
    always_ff @(posedge vpg_pclk or negedge rst_n) begin
        if (!rst_n) begin
            vs_d      <= ~VS_POL;
            pos_x     <= '0;
            pos_y     <= '0;
            dir_x     <= 1'b0;
            dir_y     <= 1'b0;
            frame_cnt <= '0;
        end else begin
            vs_d <= vpg_vs;
            if (state == WAIT_VS && frame_en && vs_edge)
                frame_cnt <= frame_cnt + 16'd1;
            if (state == CALC && !hold) begin
                pos_x <= nxt_x;
                pos_y <= nxt_y;
                dir_x <= dir_x ^ flip_x;
                dir_y <= dir_y ^ flip_y;
            end
        end
    end
endmodule

// File: tb/tb_square_motion_ctrl.sv
// tb_square_motion_ctrl: randomized and directed bench for square_motion_ctrl
// Uses small screen parameters so bounces happen within a few frames.
module tb_square_motion_ctrl;
    localparam int SX = 16, QX = 4, PX = 5, SY = 10, QY = 4, PY = 3;
    localparam int MXX = SX - QX, MXY = SY - QY;
    logic clk = 0, rst_n = 0, vs = 0, frame_en = 0, ready = 1, pause = 0;
    logic pos_valid, dir_x, dir_y, bounce, overrun;
    logic [11:0] pos_x, pos_y;
    logic [15:0] frame_cnt;
    int errors = 0, checks = 0;
    int m_x, m_y, m_cnt, m_age;
    bit m_dx, m_dy, m_armed, m_vs_prev;
    int bounce_cnt = 0, over_cnt = 0, hs_cnt = 0;
    int ex[7] = '{5, 10, 12, 7, 2, 0, 5};
    int ey[7] = '{3, 6, 3, 0, 3, 6, 3};
    int edx[7] = '{0, 0, 1, 1, 1, 0, 0};
    int edy[7] = '{0, 1, 1, 0, 0, 1, 1};
    int eb[7] = '{0, 1, 1, 1, 0, 1, 0};

    always #5 clk = ~clk;

    square_motion_ctrl #(.SCREEN_X(SX), .SCREEN_Y(SY), .SQUARE_X(QX), .SQUARE_Y(QY),
                         .STEP_X(PX), .STEP_Y(PY), .VS_POL(1'b1)) dut (
        .vpg_pclk(clk), .rst_n(rst_n), .vpg_vs(vs), .frame_en(frame_en), .pos_ready(ready),
`ifdef SQUARE_PAUSE_EN
        .pause(pause),
`endif
        .pos_valid(pos_valid), .pos_x(pos_x), .pos_y(pos_y), .dir_x(dir_x), .dir_y(dir_y),
        .bounce(bounce), .overrun(overrun), .frame_cnt(frame_cnt));

    function automatic bit paused();
`ifdef SQUARE_PAUSE_EN
        return pause;
`else
        return 1'b0;
`endif
    endfunction

    // one frame of bouncing motion on one axis, straight from the movement rules
    function automatic void mv(input int p, input bit d, input int st, input int mx,
                               output int np, output bit nd);
        if (!d) begin
            if (p + st >= mx) begin np = mx; nd = 1; end
            else begin np = p + st; nd = 0; end
        end else begin
            if (p <= st) begin np = 0; nd = 0; end
            else begin np = p - st; nd = 1; end
        end
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int gap);
        vs = 1;
        step_n(2);
        vs = 0;
        step_n(gap);
    endtask

    // reference model: age counts cycles since an accepted vsync (0 = no frame in flight)
    always @(posedge clk) begin
        bit e;
        int nx, ny;
        bit ndx, ndy;
        if (!rst_n) begin
            m_x = 0; m_y = 0; m_dx = 0; m_dy = 0; m_cnt = 0; m_age = 0;
            m_armed = 0; m_vs_prev = 0;
        end else begin
            e = vs && !m_vs_prev;
            m_vs_prev = vs;
            if (m_age == 0) begin
                if (!m_armed) m_armed = frame_en;
                else if (!frame_en) m_armed = 0;
                else if (e) begin m_cnt = (m_cnt + 1) % 65536; m_age = 1; end
            end else if (m_age == 1) begin
                if (!paused()) begin
                    mv(m_x, m_dx, PX, MXX, nx, ndx);
                    mv(m_y, m_dy, PY, MXY, ny, ndy);
                    m_x = nx; m_y = ny; m_dx = ndx; m_dy = ndy;
                end
                m_age = 2;
            end else if (ready) begin
                m_age = 0;
                m_armed = frame_en;
            end
        end
    end

    always @(negedge clk) begin
        logic [44:0] exp_v, act_v;
        int nx, ny;
        bit ndx, ndy, eb_now, eo_now;
        if (!rst_n) exp_v = '0;
        else begin
            mv(m_x, m_dx, PX, MXX, nx, ndx);
            mv(m_y, m_dy, PY, MXY, ny, ndy);
            eb_now = (m_age == 1) && !paused() && ((ndx != m_dx) || (ndy != m_dy));
            eo_now = vs && !m_vs_prev && (m_age >= 1);
            exp_v = {m_age >= 2, 12'(m_x), 12'(m_y), m_dx, m_dy, eb_now, eo_now, 16'(m_cnt)};
        end
        act_v = {pos_valid, pos_x, pos_y, dir_x, dir_y, bounce, overrun, frame_cnt};
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL cycle_cmp t=%0t: got v=%b x=%0d y=%0d dx=%b dy=%b b=%b o=%b cnt=%0d expected v=%b x=%0d y=%0d dx=%b dy=%b b=%b o=%b cnt=%0d",
                     $time, act_v[44], act_v[43:32], act_v[31:20], act_v[19], act_v[18], act_v[17], act_v[16], act_v[15:0],
                     exp_v[44], exp_v[43:32], exp_v[31:20], exp_v[19], exp_v[18], exp_v[17], exp_v[16], exp_v[15:0]);
        end
        if (bounce === 1'b1) bounce_cnt++;
        if (overrun === 1'b1) over_cnt++;
        if (pos_valid === 1'b1 && ready) hs_cnt++;
    end

    initial begin
        int b0, o0, h0, c0, x0;
        rst_n = 0; frame_en = 1; ready = 1;
        step_n(3);
        check("rst_valid", pos_valid, 0);
        check("rst_pos", {pos_x, pos_y}, 0);
        check("rst_cnt", frame_cnt, 0);
        rst_n = 1;
        step_n(2);
        check("wait_valid", pos_valid, 0);
        for (int i = 0; i < 7; i++) begin
            b0 = bounce_cnt;
            pulse(8);
            check($sformatf("t2_x%0d", i), pos_x, ex[i]);
            check($sformatf("t3_y%0d", i), pos_y, ey[i]);
            check($sformatf("t2_dx%0d", i), dir_x, edx[i]);
            check($sformatf("t3_dy%0d", i), dir_y, edy[i]);
            check($sformatf("bounce%0d", i), bounce_cnt - b0, eb[i]);
            check($sformatf("cnt%0d", i), frame_cnt, i + 1);
        end
        ready = 0; vs = 1;
        step_n(1);
        check("t4_calc_valid", pos_valid, 0);
        step_n(1);
        check("t4_e2_valid", pos_valid, 1);
        vs = 0;
        step_n(20);
        check("t4_hold_valid", pos_valid, 1);
        check("t4_hold_x", pos_x, 10);
        check("t4_hold_y", pos_y, 0);
        o0 = over_cnt;
        vs = 1;
        step_n(2);
        vs = 0;
        step_n(3);
        check("t5_overrun", over_cnt - o0, 1);
        check("t5_cnt", frame_cnt, 8);
        check("t5_x", pos_x, 10);
        ready = 1;
        step_n(1);
        check("t4_drop_valid", pos_valid, 0);
        ready = 0; vs = 1;
        step_n(2);
        frame_en = 0; vs = 0;
        step_n(3);
        check("fe_drop_valid", pos_valid, 1);
        ready = 1;
        step_n(4);
        pulse(5);
        check("fe_idle_cnt", frame_cnt, 9);
        check("fe_idle_x", pos_x, 12);
        frame_en = 1;
        step_n(2);
        ready = 0; vs = 1;
        step_n(2);
        vs = 0;
        rst_n = 0;
        #1;
        check("rst_mid_valid", pos_valid, 0);
        check("rst_mid_x", pos_x, 0);
        step_n(2);
        rst_n = 1; ready = 1;
        step_n(2);
`ifdef SQUARE_PAUSE_EN
        pause = 1; x0 = pos_x; h0 = hs_cnt; c0 = frame_cnt;
        for (int i = 0; i < 3; i++) pulse(6);
        check("t6_x", pos_x, x0);
        check("t6_hs", hs_cnt - h0, 3);
        check("t6_cnt", frame_cnt, c0 + 3);
        pause = 0;
`endif
        for (int i = 0; i < 600; i++) begin
            vs = ($urandom_range(0, 5) == 0);
            ready = ($urandom_range(0, 2) != 0);
            frame_en = ($urandom_range(0, 30) != 0);
`ifdef SQUARE_PAUSE_EN
            pause = ($urandom_range(0, 4) == 0);
`endif
            rst_n = ($urandom_range(0, 249) != 0);
            step_n(1);
        end
        rst_n = 1; vs = 0; ready = 1;
        step_n(4);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
